parking_occupancy_counter: RTL

Tracks car occupancy of the parking lot from the entry and exit gate sensors and drives the gate. Raw sensor levels are synchronised, debounced and edge-detected. A gate state machine admits or rejects each car and keeps a saturating occupancy count. It produces the packed 12-bit status word `s1a` that the seven-segment display stage directly downstream multiplexes onto the digits.

---
 rtl/parking_occupancy_counter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/parking_occupancy_counter.sv
// rtl/parking_occupancy_counter.sv - lot occupancy tracker with debounced gate sensors and gate FSM
// Optional feature macro: PARKING_REJECT_COUNT_EN (s1a[5:3] becomes a saturating refused-entry count).
module parking_occupancy_counter #(
    parameter int CAPACITY        = 6,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int GATE_CYCLES     = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        car_in_raw,
    input  logic        car_out_raw,
    output logic [11:0] s1a,
    output logic        full,
    output logic        empty,
    output logic        gate_open,
    output logic        reject
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] GATE_LOAD  = TW'(GATE_CYCLES - 1);
    localparam logic [2:0]    CAP3       = 3'(CAPACITY);
`ifdef PARKING_REJECT_COUNT_EN
    localparam logic [2:0]    MID_RESET  = 3'd0;
`else
    localparam logic [2:0]    MID_RESET  = CAP3;
`endif

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GATE_IN  = 2'd1,
        GATE_OUT = 2'd2
    } state_t;

    // Sensor index 0 is the entry gate, index 1 the exit gate.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    filt;
    logic [1:0]    filt_q;
    logic [1:0]    req;
    logic [DW-1:0] db_cnt [2];

    logic          pend_in;
    logic          pend_out;
    logic          clr_in;
    logic          clr_out;

    state_t        state;
    state_t        state_next;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_next;
    logic [2:0]    occ;
    logic [2:0]    occ_next;
    logic          reject_next;
    logic [2:0]    mid_next;

    assign raw = {car_out_raw, car_in_raw};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Filtered level follows the synchronised level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt   <= '0;
            filt_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    filt[i]   <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign req = filt & ~filt_q;

    // A request landing on an already-set flag is dropped; clear only happens while the flag is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_in  <= 1'b0;
            pend_out <= 1'b0;
        end else begin
            if (clr_in) begin
                pend_in <= 1'b0;
            end else if (req[0]) begin
                pend_in <= 1'b1;
            end
            if (clr_out) begin
                pend_out <= 1'b0;
            end else if (req[1]) begin
                pend_out <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
            occ   <= 3'd0;
        end else begin
            state <= state_next;
            timer <= timer_next;
            occ   <= occ_next;
        end
    end

    always_comb begin
        state_next  = state;
        timer_next  = timer;
        occ_next    = occ;
        clr_in      = 1'b0;
        clr_out     = 1'b0;
        reject_next = 1'b0;
        case (state)
            IDLE: begin
                if (pend_out) begin
                    clr_out = 1'b1;
                    if (occ != 3'd0) begin
                        occ_next   = occ - 1'b1;
                        timer_next = GATE_LOAD;
                        state_next = GATE_OUT;
                    end
                end else if (pend_in) begin
                    clr_in = 1'b1;
                    if (occ == CAP3) begin
                        reject_next = 1'b1;
                    end else begin
                        occ_next   = occ + 1'b1;
                        timer_next = GATE_LOAD;
                        state_next = GATE_IN;
                    end
                end
            end
            GATE_IN, GATE_OUT: begin
                if (timer == '0) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                timer_next = '0;
            end
        endcase
    end

    always_comb begin
        gate_open = (state != IDLE);
    end

`ifdef PARKING_REJECT_COUNT_EN
    logic [2:0] rej_cnt;

    always_comb begin
        mid_next = rej_cnt;
        if (reject_next && (rej_cnt != 3'd7)) begin
            mid_next = rej_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rej_cnt <= 3'd0;
        end else begin
            rej_cnt <= mid_next;
        end
    end
`else
    always_comb begin
        mid_next = CAP3;
    end
`endif

    // Status outputs are registered from the next occupancy so they change on the same edge as the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1a    <= {CAP3, 3'd0, MID_RESET, CAP3};
            full   <= 1'b0;
            empty  <= 1'b1;
            reject <= 1'b0;
        end else begin
            s1a    <= {CAP3, occ_next, mid_next, CAP3 - occ_next};
            full   <= (occ_next == CAP3);
            empty  <= (occ_next == 3'd0);
            reject <= reject_next;
        end
    end

endmodule
